// File: rtl/neokeon_arbiter.sv
// Round-robin front end that shares one Neokeon core between two requesters,
// with a last-key cache so an unchanged key is not rewritten into the core.
module neokeon_arbiter #(
    parameter int START_TIMEOUT = 8
) (
    input  logic         inClk,
    input  logic         inRst,
    input  logic         inReq0Valid,
    input  logic [127:0] inReq0Key,
    input  logic [127:0] inReq0Data,
    output logic         outReq0Ready,
    input  logic         inReq1Valid,
    input  logic [127:0] inReq1Key,
    input  logic [127:0] inReq1Data,
    output logic         outReq1Ready,
    output logic         outRsp0Valid,
    output logic [127:0] outRsp0Data,
    input  logic         inRsp0Ready,
    output logic         outRsp1Valid,
    output logic [127:0] outRsp1Data,
    input  logic         inRsp1Ready,
    output logic [127:0] outCoreKey,
    output logic [127:0] outCoreData,
    output logic         outCoreKeyWr,
    output logic         outCoreDataWr,
    input  logic [127:0] inCoreData,
    input  logic         inCoreBusy,
    output logic         outBusy,
    output logic         outErr
);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ISSUE      = 3'd1,
        ST_WAIT_START = 3'd2,
        ST_WAIT_DONE  = 3'd3,
        ST_RESP       = 3'd4
    } state_t;

    // Counter value one step before the timeout limit is reached.
    localparam logic [7:0] TMO_LAST = 8'(START_TIMEOUT - 2);

    state_t         state_r;
    state_t         state_nx_s;
    logic [7:0]     cnt_r;
    logic [7:0]     cnt_nx_s;
    logic           grant_r;
    logic           last_r;
    logic [127:0]   job_key_r;
    logic [127:0]   job_data_r;
    logic [127:0]   cache_key_r;
    logic           cache_valid_r;
    logic [127:0]   result_r;
    logic           err_r;
    logic           key_wr_r;
    logic           data_wr_r;
    logic           rsp0_valid_r;
    logic           rsp1_valid_r;
    logic           busy_r;

    logic           grant0_s;
    logic           grant1_s;
    logic           accept_s;
    logic [127:0]   sel_key_s;
    logic [127:0]   sel_data_s;
    logic           key_hit_s;
    logic           key_wr_nx_s;
    logic           data_wr_nx_s;
    logic           timeout_s;
    logic           load_result_s;
    logic           rsp_done_s;

    // Requester selection; ties go to whoever was not served last.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if ((state_r == ST_IDLE) && !inRst) begin
            if (inReq0Valid && inReq1Valid) begin
                grant0_s = last_r;
                grant1_s = ~last_r;
            end else begin
                grant0_s = inReq0Valid;
                grant1_s = inReq1Valid;
            end
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    assign accept_s   = grant0_s | grant1_s;
    assign sel_key_s  = grant1_s ? inReq1Key  : inReq0Key;
    assign sel_data_s = grant1_s ? inReq1Data : inReq0Data;
    assign key_hit_s  = cache_valid_r && (sel_key_s == cache_key_r);

    // Next-state and per-state control decisions.
    always_comb begin
        state_nx_s    = state_r;
        cnt_nx_s      = cnt_r;
        key_wr_nx_s   = 1'b0;
        data_wr_nx_s  = 1'b0;
        timeout_s     = 1'b0;
        load_result_s = 1'b0;
        rsp_done_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nx_s   = ST_ISSUE;
                    data_wr_nx_s = 1'b1;
                    key_wr_nx_s  = ~key_hit_s;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                cnt_nx_s   = 8'd0;
                state_nx_s = ST_WAIT_START;
            end
            ST_WAIT_START: begin
                if (inCoreBusy) begin
                    state_nx_s = ST_WAIT_DONE;
                end else if (cnt_r == TMO_LAST) begin
                    timeout_s  = 1'b1;
                    state_nx_s = ST_RESP;
                end else begin
                    cnt_nx_s = cnt_r + 8'd1;
                end
            end
            ST_WAIT_DONE: begin
                if (!inCoreBusy) begin
                    load_result_s = 1'b1;
                    state_nx_s    = ST_RESP;
                end else begin
                    state_nx_s = ST_WAIT_DONE;
                end
            end
            ST_RESP: begin
                if (grant_r ? inRsp1Ready : inRsp0Ready) begin
                    rsp_done_s = 1'b1;
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_RESP;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Control state, strobes and response flags, all registered.
    always_ff @(posedge inClk) begin
        if (inRst) begin
            state_r      <= ST_IDLE;
            cnt_r        <= 8'd0;
            grant_r      <= 1'b0;
            last_r       <= 1'b1;
            key_wr_r     <= 1'b0;
            data_wr_r    <= 1'b0;
            rsp0_valid_r <= 1'b0;
            rsp1_valid_r <= 1'b0;
            busy_r       <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            state_r      <= state_nx_s;
            cnt_r        <= cnt_nx_s;
            key_wr_r     <= key_wr_nx_s;
            data_wr_r    <= data_wr_nx_s;
            rsp0_valid_r <= (state_nx_s == ST_RESP) && !grant_r;
            rsp1_valid_r <= (state_nx_s == ST_RESP) && grant_r;
            busy_r       <= (state_nx_s != ST_IDLE);
            if (accept_s) begin
                grant_r <= grant1_s;
            end
            if (rsp_done_s) begin
                last_r <= grant_r;
            end
            if (timeout_s) begin
                err_r <= 1'b1;
            end
        end
    end

    // Job capture, key cache and result register.
    always_ff @(posedge inClk) begin
        if (inRst) begin
            job_key_r     <= 128'd0;
            job_data_r    <= 128'd0;
            cache_key_r   <= 128'd0;
            cache_valid_r <= 1'b0;
            result_r      <= 128'd0;
        end else begin
            if (accept_s) begin
                job_key_r  <= sel_key_s;
                job_data_r <= sel_data_s;
            end
            // key_wr_r is high only during ISSUE, so the cache tracks the core.
            if (key_wr_r) begin
                cache_key_r   <= job_key_r;
                cache_valid_r <= 1'b1;
            end
            if (timeout_s) begin
                cache_valid_r <= 1'b0;
                result_r      <= 128'd0;
            end
            if (load_result_s) begin
                result_r <= inCoreData;
            end
        end
    end

    assign outReq0Ready  = grant0_s;
    assign outReq1Ready  = grant1_s;
    assign outRsp0Valid  = rsp0_valid_r;
    assign outRsp1Valid  = rsp1_valid_r;
    assign outRsp0Data   = result_r;
    assign outRsp1Data   = result_r;
    assign outCoreKey    = job_key_r;
    assign outCoreData   = job_data_r;
    assign outCoreKeyWr  = key_wr_r;
    assign outCoreDataWr = data_wr_r;
    assign outBusy       = busy_r;
    assign outErr        = err_r;

endmodule

// File: tb/tb_neokeon_arbiter.sv
// Directed bench for neokeon_arbiter with a behavioural core that raises busy
// for a programmable number of cycles after each data strobe.
module tb_neokeon_arbiter;

    logic         inClk = 1'b0;
    logic         inRst;
    logic         inReq0Valid, inReq1Valid;
    logic [127:0] inReq0Key, inReq0Data, inReq1Key, inReq1Data;
    logic         outReq0Ready, outReq1Ready;
    logic         outRsp0Valid, outRsp1Valid;
    logic [127:0] outRsp0Data, outRsp1Data;
    logic         inRsp0Ready, inRsp1Ready;
    logic [127:0] outCoreKey, outCoreData;
    logic         outCoreKeyWr, outCoreDataWr;
    logic [127:0] inCoreData = 128'd0;
    logic         inCoreBusy = 1'b0;
    logic         outBusy, outErr;

    int total = 0;
    int bad   = 0;

    int           core_b    = 0;
    bit           core_on   = 1'b0;
    int           busy_left = 0;
    logic [127:0] core_key  = 128'd0;

    localparam logic [127:0] K_A = 128'hb1656851699e29fa24b70148503d2dfc;
    localparam logic [127:0] D_A = 128'h2a78421b87c7d0924f26113f1d1349b2;
    localparam logic [127:0] K_B = 128'h0123456789abcdef_fedcba9876543210;
    localparam logic [127:0] D_B = 128'hdeadbeef_cafef00d_12345678_9abcdef0;
    localparam logic [127:0] K_C = 128'h55aa55aa_00ff00ff_f0f0f0f0_13572468;
    localparam logic [127:0] D_C = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;

    neokeon_arbiter #(.START_TIMEOUT(8)) dut (
        .inClk(inClk), .inRst(inRst),
        .inReq0Valid(inReq0Valid), .inReq0Key(inReq0Key), .inReq0Data(inReq0Data),
        .outReq0Ready(outReq0Ready),
        .inReq1Valid(inReq1Valid), .inReq1Key(inReq1Key), .inReq1Data(inReq1Data),
        .outReq1Ready(outReq1Ready),
        .outRsp0Valid(outRsp0Valid), .outRsp0Data(outRsp0Data), .inRsp0Ready(inRsp0Ready),
        .outRsp1Valid(outRsp1Valid), .outRsp1Data(outRsp1Data), .inRsp1Ready(inRsp1Ready),
        .outCoreKey(outCoreKey), .outCoreData(outCoreData),
        .outCoreKeyWr(outCoreKeyWr), .outCoreDataWr(outCoreDataWr),
        .inCoreData(inCoreData), .inCoreBusy(inCoreBusy),
        .outBusy(outBusy), .outErr(outErr)
    );

    always #5 inClk = ~inClk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Stand-in cipher: any fixed mix of key and data will do for routing checks.
    function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] d);
        return {d[63:0], d[127:64]} ^ k ^ {4{32'h9e3779b9}};
    endfunction

    // Behavioural core: busy for core_b cycles starting the cycle after the strobe.
    always @(negedge inClk) begin
        if (busy_left > 0) begin
            inCoreBusy = 1'b1;
            busy_left  = busy_left - 1;
        end else begin
            inCoreBusy = 1'b0;
        end
        if (outCoreKeyWr) core_key = outCoreKey;
        if (outCoreDataWr && core_on) begin
            busy_left  = core_b;
            inCoreData = core_fn(core_key, outCoreData);
        end
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic req_rdy(input int r);
        return (r == 0) ? outReq0Ready : outReq1Ready;
    endfunction
    function automatic logic rsp_v(input int r);
        return (r == 0) ? outRsp0Valid : outRsp1Valid;
    endfunction
    function automatic logic [127:0] rsp_d(input int r);
        return (r == 0) ? outRsp0Data : outRsp1Data;
    endfunction

    task automatic do_reset();
        inRst = 1'b1;
        @(negedge inClk);
        @(negedge inClk);
        inRst = 1'b0;
        @(negedge inClk);
    endtask

    // Called at a negedge with the arbiter idle; returns at the negedge after the handshake.
    // bcyc == 0 means the core never starts (timeout path).
    task automatic run_job(input int req, input logic [127:0] key, input logic [127:0] data,
                           input int bcyc, input logic exp_kw, input bit hold, input int bp);
        logic [127:0] exp_res;
        int  n;
        int  err_n;
        bit  other_seen;
        if (req == 0) begin
            inReq0Key = key; inReq0Data = data; inReq0Valid = 1'b1;
        end else begin
            inReq1Key = key; inReq1Data = data; inReq1Valid = 1'b1;
        end
        core_on = (bcyc > 0);
        core_b  = bcyc;
        exp_res = (bcyc > 0) ? core_fn(key, data) : 128'd0;
        #1;
        check_eq("req_ready", 128'(req_rdy(req)), 128'd1);
        check_eq("other_ready", 128'(req_rdy(1 - req)), 128'd0);
        @(negedge inClk);
        if (!hold) begin
            if (req == 0) inReq0Valid = 1'b0;
            else inReq1Valid = 1'b0;
        end
        check_eq("data_wr", 128'(outCoreDataWr), 128'd1);
        check_eq("key_wr", 128'(outCoreKeyWr), 128'(exp_kw));
        check_eq("core_key", outCoreKey, key);
        check_eq("core_data", outCoreData, data);
        check_eq("busy_flag", 128'(outBusy), 128'd1);
        if (bcyc == 0) check_eq("err_before", 128'(outErr), 128'd0);
        n = 0;
        err_n = -1;
        other_seen = 1'b0;
        while (!rsp_v(req) && n < 40) begin
            @(negedge inClk);
            n++;
            if (n == 1) check_eq("wr_pulse", 128'({outCoreKeyWr, outCoreDataWr}), 128'd0);
            if (rsp_v(1 - req)) other_seen = 1'b1;
            if (outErr && err_n < 0) err_n = n;
        end
        check_eq("rsp_latency", 128'(n), (bcyc > 0) ? 128'(bcyc + 2) : 128'd8);
        if (bcyc == 0) begin
            check_eq("err_rise", 128'(err_n), 128'd8);
            check_eq("err_set", 128'(outErr), 128'd1);
        end
        check_eq("rsp_data", rsp_d(req), exp_res);
        check_eq("rsp_other", 128'(other_seen | rsp_v(1 - req)), 128'd0);
        if (bp > 0) begin
            inReq1Valid = 1'b1;
            inRsp1Ready = 1'b1;
        end
        repeat (bp) begin
            @(negedge inClk);
            check_eq("bp_valid", 128'(rsp_v(req)), 128'd1);
            check_eq("bp_data", rsp_d(req), exp_res);
            check_eq("bp_req1_ready", 128'(outReq1Ready), 128'd0);
        end
        inRsp1Ready = 1'b0;
        if (req == 0) inRsp0Ready = 1'b1;
        else inRsp1Ready = 1'b1;
        @(negedge inClk);
        inRsp0Ready = 1'b0;
        inRsp1Ready = 1'b0;
        check_eq("rsp_drop", 128'(rsp_v(req)), 128'd0);
        check_eq("idle_busy", 128'(outBusy), 128'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ready"}, 128'({outReq0Ready, outReq1Ready}), 128'd0);
        check_eq({tag, "_rspv"}, 128'({outRsp0Valid, outRsp1Valid}), 128'd0);
        check_eq({tag, "_wr"}, 128'({outCoreKeyWr, outCoreDataWr}), 128'd0);
        check_eq({tag, "_busy_err"}, 128'({outBusy, outErr}), 128'd0);
        check_eq({tag, "_rsp_data"}, outRsp0Data | outRsp1Data, 128'd0);
        check_eq({tag, "_core_key"}, outCoreKey, 128'd0);
        check_eq({tag, "_core_data"}, outCoreData, 128'd0);
    endtask

    initial begin
        bit seen;
        inRst = 1'b1;
        inReq0Valid = 1'b0; inReq1Valid = 1'b0;
        inReq0Key = 128'd0; inReq0Data = 128'd0;
        inReq1Key = 128'd0; inReq1Data = 128'd0;
        inRsp0Ready = 1'b0; inRsp1Ready = 1'b0;
        repeat (3) @(negedge inClk);
        check_reset_outputs("reset");
        inRst = 1'b0;
        @(negedge inClk);

        // Single job, then key cache hit and miss.
        run_job(0, K_A, D_A, 3, 1'b1, 1'b0, 0);
        run_job(0, K_A, D_B, 2, 1'b0, 1'b0, 0);
        run_job(0, K_B, D_C, 1, 1'b1, 1'b0, 0);

        // Response backpressure; requester 1 waits for the req0 handshake.
        inReq1Key = K_C; inReq1Data = D_B;
        run_job(0, K_B, D_A, 2, 1'b0, 1'b0, 10);
        run_job(1, K_C, D_B, 4, 1'b1, 1'b0, 0);

        // Start timeout, then the key is rewritten and jobs still run.
        run_job(0, K_C, D_C, 0, 1'b0, 1'b0, 0);
        run_job(0, K_C, D_A, 2, 1'b1, 1'b0, 0);
        check_eq("err_sticky", 128'(outErr), 128'd1);

        // Reset while the core is busy: job dropped, no response.
        inReq0Key = K_A; inReq0Data = D_B; inReq0Valid = 1'b1;
        core_on = 1'b1; core_b = 6;
        #1;
        check_eq("mid_ready", 128'(outReq0Ready), 128'd1);
        @(negedge inClk);
        inReq0Valid = 1'b0;
        @(negedge inClk);
        @(negedge inClk);
        check_eq("mid_busy", 128'(outBusy), 128'd1);
        inRst = 1'b1;
        @(negedge inClk);
        check_reset_outputs("midrst");
        inRst = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            @(negedge inClk);
            if (outRsp0Valid || outRsp1Valid || outBusy) seen = 1'b1;
        end
        check_eq("midrst_no_rsp", 128'(seen), 128'd0);

        // First job after reset writes an all-zero key.
        run_job(0, 128'd0, D_A, 2, 1'b1, 1'b0, 0);

        // Both requesters valid from reset: strict alternation starting at 0.
        do_reset();
        inReq0Key = K_A; inReq0Data = D_A; inReq0Valid = 1'b1;
        inReq1Key = K_B; inReq1Data = D_B; inReq1Valid = 1'b1;
        run_job(0, K_A, D_A, 2, 1'b1, 1'b1, 0);
        run_job(1, K_B, D_B, 1, 1'b1, 1'b1, 0);
        run_job(0, K_A, D_A, 3, 1'b1, 1'b1, 0);
        run_job(1, K_B, D_B, 2, 1'b1, 1'b1, 0);
        inReq0Valid = 1'b0;
        inReq1Valid = 1'b0;
        @(negedge inClk);
        check_eq("final_idle", 128'(outBusy), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/neokeon_arbiter.md
# neokeon_arbiter

Round-robin scheduler that shares one `Neokeon` encryption core between two requesters. It accepts a key/plaintext pair from a requester through a valid/ready handshake and drives the core's write strobes. It caches the last loaded key so that an unchanged key is not rewritten, waits for the core's busy cycle to finish, and returns the core's output to the same requester through a second valid/ready handshake. It sits between the core and the system-side request sources.

## Interface
- `START_TIMEOUT`, default 8: number of cycles to wait for `inCoreBusy` to rise after issue before declaring a fault (legal range 2..255).

- `inClk` in 1: single clock; all logic on its rising edge.
- `inRst` in 1: synchronous, active-high reset.
- `inReq0Valid` / `inReq1Valid` in 1: requester N has a pending job.
- `inReq0Key` / `inReq1Key` in 128: key for requester N.
- `inReq0Data` / `inReq1Data` in 128: plaintext for requester N.
- `outReq0Ready` / `outReq1Ready` out 1: job accepted from requester N this cycle.
- `outRsp0Valid` / `outRsp1Valid` out 1: result for requester N is available.
- `outRsp0Data` / `outRsp1Data` out 128: result; both ports carry the same result register.
- `inRsp0Ready` / `inRsp1Ready` in 1: requester N takes its result.
- `outCoreKey` / `outCoreData` out 128: core key and data buses, driven from the captured job registers.
- `outCoreKeyWr` / `outCoreDataWr` out 1: one-cycle write strobes to the core.
- `inCoreData` in 128: core result.
- `inCoreBusy` in 1: core busy flag.
- `outBusy` out 1: arbiter is not in IDLE.
- `outErr` out 1: sticky start-timeout fault.

## Operation
- FSM states: IDLE, ISSUE, WAIT_START, WAIT_DONE, RESP.

- **IDLE**
  - Grant goes to the requester with valid set.
  - If both are valid, grant the one not served last. `last` resets to 1, so requester 0 wins first.
  - `outReqNReady` = (state==IDLE) && grantN. This is combinational from the valid inputs.
  - On the handshake: capture key, data and grant index, then go to ISSUE.

- **ISSUE** (exactly 1 cycle)
  - `outCoreDataWr` = 1.
  - `outCoreKeyWr` = 1 unless the cache is valid and the captured key equals the cached key.
  - On a key write: cached key <= captured key, cache valid <= 1.
  - Clear the timeout counter. Next state: WAIT_START.

- **WAIT_START**
  - If `inCoreBusy` = 1, go to WAIT_DONE.
  - Otherwise increment the counter.
  - When the counter reaches START_TIMEOUT-1 with busy still low:
    - set `outErr`;
    - invalidate the key cache;
    - load result = 0;
    - go to RESP.

- **WAIT_DONE**
  - When `inCoreBusy` = 0, result <= `inCoreData`, go to RESP.

- **RESP**
  - `outRspNValid` = 1 for the granted requester only.
  - Hold the result stable until `inRspNReady`.
  - On the handshake: `last` <= grant index, go to IDLE.

- Request inputs are ignored outside IDLE. A requester holds valid/key/data until it sees ready.
- The result register changes only on entry to RESP.
- Key comparison is full 128-bit equality.
- Result goes to the granted requester only; `inRsp` of the other requester is ignored.

## Timing
- Reset values:
  - state = IDLE;
  - all `out*Ready`, `outRsp*Valid`, `outCore*Wr`, `outBusy` and `outErr` = 0;
  - result, core buses and cached key = 0;
  - cache invalid, `last` = 1, counter = 0.
- Reset wins over every other event and may arrive in any state. Any in-flight job is dropped with no response.
- Job accepted in cycle T:
  - strobe in T+1;
  - WAIT_START from T+2;
  - if the core raises busy in T+2 and holds it for B cycles, `outRspValid` is first high in T+B+3.
- Back-to-back jobs:
  - RESP handshake in cycle R puts the arbiter in IDLE at R+1;
  - the earliest next strobe is R+2.
- `outErr` stays high until `inRst`. Later jobs still run normally.
- `outBusy` = (state != IDLE), registered with the state.

## Test plan
- **Single job.** Req0 sends key b1656851699e29fa24b70148503d2dfc and data 2a78421b87c7d0924f26113f1d1349b2.
  - Required: one cycle with both strobes high and those buses.
  - `outRsp0Valid` rises after busy falls, with data = the core model's output; `outRsp1Valid` stays 0.
- **Simultaneous requests.** Both valid from reset.
  - Required grant order 0, 1, 0, 1 over four jobs.
  - Req1 always-valid must not starve req0.
- **Key cache.** Req0 runs two jobs with the same key, then a different key.
  - Required `outCoreKeyWr` = 1, 0, 1 while `outCoreDataWr` = 1 each time.
  - After reset, the first job writes the key even if it is all zeros.
- **Response backpressure.** Hold `inRsp0Ready` low for 10 cycles.
  - `outRsp0Valid` and data stay stable; `outReq1Ready` stays 0.
  - Requester 1 is served only after the req0 handshake.
- **Start timeout.** Core model never raises busy, START_TIMEOUT = 8.
  - `outErr` rises 8 cycles after the strobe; response data = 0.
  - The next job rewrites the key.
- **Mid-job reset.** Assert `inRst` in WAIT_DONE.
  - Next cycle: all outputs at reset values, state IDLE.
  - No `outRsp` pulse is ever produced for the dropped job.
